// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit 7-segment scanner.
// Latches the 16-bit BCD "num" bus once per frame, then drives one anode at a
// time with active-low segments. Supports per-digit blink and a global blank.
// Optional feature macro: SEG_COLON_EN (dp lights as an MM:SS colon on the
// index-1 slot during the lit half of the blink period).
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,  // clk cycles per digit slot (min 2)
  parameter int BLINK_DIV = 50       // frames per blink half-period (min 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] num,
  input  logic [3:0]  blink_mask,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_num_q, shadow_num_d;
  logic [3:0]    shadow_mask_q, shadow_mask_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  // Stays low until the first tick so the display is dark for the first slot
  // after reset instead of showing the (zero) shadow digit at index 3.
  logic          armed_q, armed_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_start_q, frame_start_d;
  logic          dp_d;

  logic          tick;
  logic          dark;
  logic [3:0]    digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Next-state: prescaler, slot index, frame latch, blink, and the output
  // pattern for the slot that will be active after this edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    presc_d       = presc_q + PW'(1);
    idx_d         = idx_q;
    shadow_num_d  = shadow_num_q;
    shadow_mask_d = shadow_mask_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    armed_d       = armed_q;
    frame_start_d = 1'b0;

    tick = (presc_q == PW'(SCAN_DIV - 1));
    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      armed_d = 1'b1;
      if (idx_q == 2'd3) begin
        frame_start_d = 1'b1;
        shadow_num_d  = num;
        shadow_mask_d = blink_mask;
        if (frame_cnt_q == FW'(BLINK_DIV - 1)) begin
          frame_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end
    end

    // Index 0 is the leftmost digit: nibble [15:12], mask bit 3, i.e. 3-idx.
    digit = shadow_num_d[{~idx_d, 2'b00} +: 4];
    dark  = !armed_d || blank || (shadow_mask_d[~idx_d] && blink_phase_d);
    an_d  = dark ? 4'b1111 : ~(4'b1000 >> idx_d);
    seg_d = dark ? 7'h7F : decode(digit);
`ifdef SEG_COLON_EN
    dp_d  = !(!dark && (idx_d == 2'd1) && !blink_phase_d);
`else
    dp_d  = 1'b1;
`endif
  end

  // State and registered outputs; async reset forces the display off at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q       <= '0;
      idx_q         <= 2'd3;
      shadow_num_q  <= '0;
      shadow_mask_q <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      armed_q       <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'h7F;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_num_q  <= shadow_num_d;
      shadow_mask_q <= shadow_mask_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      armed_q       <= armed_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef SEG_COLON_EN
  logic dp_q;

  // Colon flop, reset to off with the rest of the display.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) dp_q <= 1'b1;
    else         dp_q <= dp_d;
  end

  assign dp = dp_q;
`else
  assign dp = dp_d;
`endif

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=4, BLINK_DIV=2).
// A reference model pushes the expected output word after each clock edge;
// a monitor pops and compares on the falling edge. Directed checks with
// hand-computed constants cover the key points of each scenario.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] num = 16'h1234;
  logic [3:0]  blink_mask = 4'b0000;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_last;

  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .resetn(resetn), .num(num), .blink_mask(blink_mask),
    .blank(blank), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Hand-written active-low patterns {g,f,e,d,c,b,a}.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
  end

  // Reference model: slot timer, digit position, frame snapshot, blink state.
  int          m_cyc;
  int          m_pos;
  logic [15:0] m_num;
  logic [3:0]  m_mask;
  int          m_frames;
  logic        m_phase;
  logic        m_started;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cyc = 0; m_pos = 3; m_num = 16'h0; m_mask = 4'h0;
      m_frames = 0; m_phase = 1'b0; m_started = 1'b0;
      exp_q.delete();
    end else begin
      exp_t e;
      logic fs;
      logic off;
      fs = 1'b0;
      m_cyc++;
      if (m_cyc == SD) begin
        m_cyc = 0;
        m_started = 1'b1;
        if (m_pos == 3) begin
          fs = 1'b1;
          m_pos = 0;
          m_num = num;
          m_mask = blink_mask;
          m_frames++;
          if (m_frames == BD) begin
            m_frames = 0;
            m_phase = ~m_phase;
          end
        end else begin
          m_pos++;
        end
      end
      off = !m_started || blank || (m_mask[3 - m_pos] && m_phase);
      e.fs  = fs;
      e.an  = off ? 4'b1111 : 4'(~(4'b1000 >> m_pos));
      e.seg = off ? 7'h7F : seg_tab[(m_num >> (4 * (3 - m_pos))) & 16'hF];
`ifdef SEG_COLON_EN
      e.dp  = (!off && m_pos == 1 && !m_phase) ? 1'b0 : 1'b1;
`else
      e.dp  = 1'b1;
`endif
      exp_last = e;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares the DUT on every falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_fs", 32'(frame_start), 32'h0);
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("mon_an", 32'(an), 32'(e.an));
      check("mon_seg", 32'(seg), 32'(e.seg));
      check("mon_dp", 32'(dp), 32'(e.dp));
      check("mon_fs", 32'(frame_start), 32'(e.fs));
    end
  end

  task automatic wait_an(input logic [3:0] v);
    int n;
    n = 0;
    while (an !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_an", 32'(an), 32'(v));
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (frame_start !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_fs", 32'(frame_start), 32'h1);
  endtask

  initial begin
    // 1. reset, release with 1234
    #1 resetn = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("rst_hold_an", 32'(an), 32'hF);
    @(negedge clk); #1 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("pre_tick_an", 32'(an), 32'hF);
      check("pre_tick_seg", 32'(seg), 32'h7F);
    end
    @(posedge clk); #1;
    check("first_an", 32'(an), 32'b0111);
    check("first_seg", 32'(seg), 32'b1111001);
    check("first_fs", 32'(frame_start), 32'h1);
    @(posedge clk); #1;
    check("fs_one_cycle", 32'(frame_start), 32'h0);

    // 2. steady 1234 for two frames
    repeat (32) @(negedge clk);

    // 3. switch to 5959 mid-frame
    wait_an(4'b1011);
    #1 num = 16'h5959;
    @(posedge clk); #1;
    check("no_tear_seg", 32'(seg), 32'b0100100);
    wait_fs();
    check("new_d0_seg", 32'(seg), 32'b0010010);
    repeat (SD) @(posedge clk);
    #1 check("new_d1_seg", 32'(seg), 32'b0010000);
    repeat (16) @(negedge clk);

    // 4. blink the two rightmost digits
    @(negedge clk); #1 blink_mask = 4'b0011;
    repeat (16 * 6) @(negedge clk);
    #1 blink_mask = 4'b0000;
    repeat (32) @(negedge clk);

    // 5. invalid BCD and a one-cycle blank
    #1 num = 16'hA0F0;
    wait_fs();
    check("bcd_a_seg", 32'(seg), 32'h7F);
    check("bcd_a_an", 32'(an), 32'b0111);
    @(posedge clk); #1 blank = 1'b1;
    @(posedge clk); #1 blank = 1'b0;
    check("blank_an", 32'(an), 32'hF);
    check("blank_seg", 32'(seg), 32'h7F);
    @(posedge clk); #1;
    check("blank_resume_an", 32'(an), 32'b0111);
    repeat (32) @(negedge clk);

    // 6. mid-slot async reset at index 2
    #1 num = 16'h1234;
    wait_an(4'b1101);
    #1 resetn = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp", 32'(dp), 32'h1);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (SD) @(posedge clk);
    #1;
    check("rerun_an", 32'(an), 32'b0111);
    check("rerun_seg", 32'(seg), 32'b1111001);
    check("rerun_fs", 32'(frame_start), 32'h1);
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed 4-digit 7-segment scanner. It sits directly downstream of the 16-bit BCD "num" bus that the service blocks produce. Each frame it latches the 4 BCD digits, then drives one anode at a time, with active-low segments. It supports per-digit blink, used to show which digit is being edited in time/alarm set, plus a global blank.

Parameters:
SCAN_DIV, 100000, clk cycles each digit slot is held (min 2)
BLINK_DIV, 50, frames per blink half-period (min 1)

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
num  in  16  BCD digits; [15:12] leftmost, [3:0] rightmost
blink_mask  in  4  bit3 = leftmost digit; 1 = digit blinks
blank  in  1  1 = all digits off
an  out  4  anodes, active-low; an[3] = leftmost
seg  out  7  cathodes, active-low, {g,f,e,d,c,b,a}
dp  out  1  decimal point, active-low
frame_start  out  1  1-cycle pulse when the digit-0 slot begins

Behaviour:
- Reset state (async, immediate): an=4'b1111, seg=7'h7F, dp=1, frame_start=0. Internal state: prescaler=0, digit index=3, shadow num=0, shadow mask=0, frame count=0, blink_phase=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. The wrap edge is the "tick".
- On each tick the index advances 3->0->1->2->3. The first tick occurs SCAN_DIV cycles after reset release.
- Index 0 is the leftmost digit and drives an=0111. Index 1 drives 1011, index 2 drives 1101, index 3 drives 1110.
- Tick with index 3->0 (frame start), on the same edge:
  - shadow num <= num, shadow mask <= blink_mask.
  - frame_start=1 for exactly that cycle.
  - Frame count increments. At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- an, seg and dp are registered and update on the tick edge for the new index, so there is no extra latency.
  - At a frame-start edge the digit-0 decode uses the num/blink_mask values being latched on that edge, and the new blink_phase.
- num changes mid-frame are ignored until the next frame start, so there is no tearing.
- Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values A-F give 1111111.
- A slot is dark (an=1111, seg=7F, dp=1) when either condition holds:
  - blank=1, or
  - the shadow mask bit for that slot is 1 and blink_phase=1.
- blank is sampled every cycle, not per frame. Its assertion or deassertion takes effect on the next clk edge, mid-slot.
- Outputs never assert two anodes at once. Mid-frame async reset forces all-off on the same instant.

Optional Feature:
SEG_COLON_EN
- Defined: dp=0 while index 1 is active, blink_phase=0, and the slot is not dark. This gives an MM:SS colon blinking at the blink rate. dp=1 otherwise.
- Not defined: dp is tied to 1 constantly.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
1. Reset held 10 cycles, then released with num=16'h1234:
   - During reset and for 4 cycles after release: an=1111, seg=7F.
   - At cycle 4: an=0111, seg=1111001, frame_start=1 for one cycle.
2. num=16'h1234 steady: each slot lasts 4 cycles, frame period 16, repeating.
   - an/seg sequence: 0111/1111001, 1011/0100100, 1101/0110000, 1110/0011001.
3. num switched to 16'h5959 while an=1011: the remaining slots show 3, 4. The next frame shows 5 (0010010), 9 (0010000), 5, 9.
4. blink_mask=4'b0011, blank=0:
   - Frames 1-2: all four digits lit.
   - Frames 3-4: the index 2 and 3 slots show an=1111, seg=7F; digits 0-1 stay lit.
   - The pattern then repeats.
5. num=16'hA0F0 gives seg=7F in the index 0 and 2 slots. Asserting blank for 1 cycle mid-slot gives exactly 1 cycle of an=1111 on the next edge, then the slot resumes.
6. resetn pulsed low mid-slot (index 2): outputs go off immediately. After release, the first lit slot is index 0, SCAN_DIV cycles later, with frame_start.
   - With SEG_COLON_EN defined, dp=0 only during index 1 slots of blink_phase=0 frames.
